// File: rtl/scmp_bus_if_pkg.sv
// Shared types and constants for the SC/MP memory-side bus interface.
// The optional REQ timeout is enabled with SCMP_BUS_TIMEOUT_EN.
package scmp_bus_pak;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_REQ  = 2'd1,
    BUS_DONE = 2'd2
  } BUS_ST_t;

  // Status flag positions within D_o[7:4] during ADS
  localparam int FLG_IX_H = 3;
  localparam int FLG_IX_D = 2;
  localparam int FLG_IX_I = 1;
  localparam int FLG_IX_R = 0;

  localparam int TIMEOUT_DEF = 255;
  localparam logic [7:0] RDATA_ABORT = 8'hFF;

endpackage

// File: rtl/scmp_bus_if_wdog.sv
// REQ-phase watchdog: counts cycles while run is high and flags expiry on the
// TIMEOUT-th cycle. Only instantiated when SCMP_BUS_TIMEOUT_EN is defined.
module scmp_bus_wdog
  import scmp_bus_pak::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (clear) begin
      cnt_q <= 8'd0;
    end else if (run && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // cnt_q is 0 on the first REQ cycle, so LAST is reached on cycle TIMEOUT
  assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/scmp_bus_if.sv
// SC/MP bus demultiplexer: latches the ADS nibble/flags, runs one req/ack
// memory transfer per strobe and stalls the core via cpu_ce meanwhile.
// Optional REQ timeout/abort: define SCMP_BUS_TIMEOUT_EN.
// Handshake: mem_req rises on entering REQ and holds mem_addr/mem_we/mem_wdata
// stable until the cycle mem_ack is sampled high; mem_ack is ignored otherwise.
module scmp_bus_if
  import scmp_bus_pak::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ADS_n,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic [11:0] addr,
  input  logic [7:0]  D_o,
  output logic [7:0]  D_i,
  output logic        cpu_ce,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        flag_h,
  output logic        flag_d,
  output logic        flag_i,
  output logic        flag_r,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  BUS_ST_t    state_q, state_d;
  logic       ads_seen_q;
  logic [3:0] addr_hi_q;
  logic [3:0] flags_q;
  logic [7:0] rdata_q;

  logic strobe;
  logic stall;
  logic capture;
  logic go_req;
  logic ack_ok;
  logic abort;
  logic tmo_hit;

  assign strobe = !RD_n || !WR_n;

  // ADS is also taken in the stalled IDLE cycle so a same-cycle ADS+strobe works
  assign capture = !ADS_n && (state_q != BUS_REQ);

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    go_req  = 1'b0;
    ack_ok  = 1'b0;
    tmo_hit = 1'b0;
    cpu_ce  = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        stall  = strobe && (ads_seen_q || !ADS_n);
        cpu_ce = !stall;
        if (strobe && ads_seen_q) begin
          go_req  = 1'b1;
          state_d = BUS_REQ;
        end
      end
      BUS_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ack_ok  = 1'b1;
          state_d = BUS_DONE;
        end else if (abort) begin
          tmo_hit = 1'b1;
          state_d = BUS_DONE;
        end
      end
      BUS_DONE: begin
        cpu_ce  = 1'b1;
        state_d = BUS_IDLE;
      end
      default: begin
        state_d = BUS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BUS_IDLE;
      ads_seen_q <= 1'b0;
      addr_hi_q  <= 4'h0;
      flags_q    <= 4'h0;
      mem_addr   <= 16'h0000;
      mem_we     <= 1'b0;
      mem_wdata  <= 8'h00;
      rdata_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_hi_q <= D_o[3:0];
        flags_q   <= D_o[7:4];
      end
      if (go_req) begin
        ads_seen_q <= 1'b0;
      end else if (capture) begin
        ads_seen_q <= 1'b1;
      end
      if (go_req) begin
        mem_addr  <= {addr_hi_q, addr};
        mem_we    <= !WR_n;
        mem_wdata <= D_o;
      end
      if (ack_ok && !mem_we) begin
        rdata_q <= mem_rdata;
      end else if (tmo_hit) begin
        rdata_q <= RDATA_ABORT;
      end
    end
  end

`ifdef SCMP_BUS_TIMEOUT_EN
  logic bus_err_q;

  scmp_bus_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q != BUS_REQ),
    .run    (state_q == BUS_REQ),
    .expired(abort)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err_q <= 1'b0;
    end else if (tmo_hit) begin
      bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign bus_err        = 1'b0;
  assign unused_timeout = ^8'(TIMEOUT);
`endif

  assign D_i       = rdata_q;
  assign flag_h    = flags_q[FLG_IX_H];
  assign flag_d    = flags_q[FLG_IX_D];
  assign flag_i    = flags_q[FLG_IX_I];
  assign flag_r    = flags_q[FLG_IX_R];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_scmp_bus_if.sv
// Directed bench for scmp_bus_if; memory transactions are checked against an
// expected queue. Timeout steps run only when SCMP_BUS_TIMEOUT_EN is defined.
module tb_scmp_bus_if;
  import scmp_bus_pak::*;

  logic        clk;
  logic        rst_n;
  logic        ADS_n, RD_n, WR_n;
  logic [11:0] addr;
  logic [7:0]  D_o;
  logic [7:0]  D_i;
  logic        cpu_ce;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        flag_h, flag_d, flag_i, flag_r;
  logic        bus_err;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // {mem_addr, mem_we, mem_wdata}
  logic [24:0] exp_q[$];

  logic [3:0]  r_nib;
  logic [11:0] r_addr;
  logic [7:0]  r_data;
  int          r_k;

  scmp_bus_if #(
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ADS_n    (ADS_n),
    .RD_n     (RD_n),
    .WR_n     (WR_n),
    .addr     (addr),
    .D_o      (D_o),
    .D_i      (D_i),
    .cpu_ce   (cpu_ce),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .flag_h   (flag_h),
    .flag_d   (flag_d),
    .flag_i   (flag_i),
    .flag_r   (flag_r),
    .bus_err  (bus_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: compare every accepted memory request against the queue
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_req", {7'd0, mem_addr, mem_we, mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        check("mem_txn", {7'd0, mem_addr, mem_we, mem_wdata}, {7'd0, exp_q.pop_front()});
      end
    end
  end

  // one core access; k<0 means never ack. Returns in the cycle after DONE.
  task automatic access(input string tag, input logic wr, input logic same,
                        input logic [7:0] ads_byte, input logic [11:0] a,
                        input logic [7:0] wd, input logic [7:0] rd, input int k,
                        input int exp_stall, input logic [7:0] exp_di, input logic hold);
    int stall;
    int waits;
    logic [7:0] wexp;
    if (!same) begin
      ADS_n = 1'b0; D_o = ads_byte; addr = a; RD_n = 1'b1; WR_n = 1'b1;
      tick();
      ADS_n = 1'b1;
      D_o   = wr ? wd : 8'h00;
      wexp  = D_o;
    end else begin
      ADS_n = 1'b0;
      D_o   = ads_byte;
      wexp  = ads_byte;
    end
    addr = a;
    RD_n = wr;
    WR_n = !wr;
    exp_q.push_back({ads_byte[3:0], a, wr, wexp});
    stall = 0;
    waits = 0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (cpu_ce) break;
      stall++;
      if (mem_req) begin
        ADS_n = 1'b1;
        if (k >= 0 && waits == k) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end else begin
          waits++;
        end
      end
      tick();
      mem_ack = 1'b0;
    end
    check({tag, "_stall"}, stall, exp_stall);
    check({tag, "_di"}, {24'd0, D_i}, {24'd0, exp_di});
    tick();
    if (!hold) begin
      RD_n = 1'b1;
      WR_n = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; ADS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
    addr = 12'h000; D_o = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
    tick();
    tick();
    #1;
    check("rst_cpu_ce", {31'd0, cpu_ce}, 32'd1);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_di", {24'd0, D_i}, 32'd0);
    check("rst_flags", {28'd0, flag_h, flag_d, flag_i, flag_r}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, BUS_IDLE});
    tick();
    rst_n = 1'b1;
    tick();

    // zero-wait read, then hold RD_n low without a new ADS
    access("rd0", 1'b0, 1'b0, 8'h9A, 12'h123, 8'h00, 8'h5C, 0, 2, 8'h5C, 1'b1);
    check("rd0_flags", {28'd0, flag_h, flag_d, flag_i, flag_r}, 32'b1001);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_cpu_ce", {31'd0, cpu_ce}, 32'd1);
      check("hold_mem_req", {31'd0, mem_req}, 32'd0);
      tick();
    end
    RD_n = 1'b1;
    tick();

    // write with three wait cycles; D_i keeps the last read value
    access("wr3", 1'b1, 1'b0, 8'h03, 12'h456, 8'h77, 8'hEE, 3, 5, 8'h5C, 1'b0);
    check("wr3_flags", {28'd0, flag_h, flag_d, flag_i, flag_r}, 32'd0);

    // ADS and RD_n low in the same cycle
    access("b2b", 1'b0, 1'b1, 8'h46, 12'hFED, 8'h00, 8'hA5, 0, 3, 8'hA5, 1'b0);
    check("b2b_flag_d", {31'd0, flag_d}, 32'd1);

    for (int i = 0; i < 3; i++) begin
      r_nib  = 4'($urandom_range(0, 15));
      r_addr = 12'($urandom_range(0, 4095));
      r_data = 8'($urandom_range(0, 255));
      r_k    = $urandom_range(0, 4);
      access("rnd", 1'b0, 1'b0, {4'h2, r_nib}, r_addr, 8'h00, r_data, r_k, r_k + 2, r_data, 1'b0);
    end

`ifdef SCMP_BUS_TIMEOUT_EN
    access("tmo", 1'b0, 1'b0, 8'h15, 12'h0AB, 8'h00, 8'h00, -1, 5, 8'hFF, 1'b0);
    check("tmo_bus_err", {31'd0, bus_err}, 32'd1);
    check("tmo_addr", {16'd0, mem_addr}, 32'h50AB);
    if (exp_q.size() != 0) exp_q.delete(0);
    mem_ack   = 1'b1;
    mem_rdata = 8'h11;
    #1;
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    tick();
    mem_ack = 1'b0;
    tick();
    check("late_ack_di", {24'd0, D_i}, 32'hFF);
    check("tmo_bus_err_sticky", {31'd0, bus_err}, 32'd1);
`endif

    // reset while a request is outstanding
    ADS_n = 1'b0; D_o = 8'h07; addr = 12'h321;
    tick();
    ADS_n = 1'b1; RD_n = 1'b0; D_o = 8'h00;
    tick();
    tick();
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, mem_req}, 32'd0);
    exp_q.delete();
    RD_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_cpu_ce", {31'd0, cpu_ce}, 32'd1);
    check("post_rst_state", {30'd0, dbg_state}, {30'd0, BUS_IDLE});
    check("post_rst_di", {24'd0, D_i}, 32'd0);
    check("post_rst_bus_err", {31'd0, bus_err}, 32'd0);

    tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
